// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encodings,
// default widths and the redirect-kind tag.
package pc_sequencer_pkg;

    localparam int          PKG_PC_WIDTH = 12;
    localparam logic [11:0] PKG_RESET_PC = 12'd0;
    localparam int          PKG_FLUSH_LEN = 1;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2
    } redir_kind_t;

    function automatic logic is_active(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_FLUSH);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC and the kind of redirect chosen.
// Purely combinational; the caller owns all state.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = PKG_PC_WIDTH
) (
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic                jump_en,
    input  logic                stall,
    input  logic [PC_WIDTH-1:0] curr_pc,
    input  logic [PC_WIDTH-1:0] next_pc_f,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                redirect,
    output redir_kind_t         kind
);

    // Branch outranks jump: it belongs to the older instruction.
    always_comb begin
        pc_next  = curr_pc;
        redirect = 1'b0;
        kind     = REDIR_NONE;
        priority case (1'b1)
            freeze: begin
                pc_next = curr_pc;
            end
            branch_taken: begin
                pc_next  = branch_target;
                redirect = 1'b1;
                kind     = REDIR_BRANCH;
            end
            jump_en: begin
                pc_next  = jump_target;
                redirect = 1'b1;
                kind     = REDIR_JUMP;
            end
            stall: begin
                pc_next = curr_pc;
            end
            default: begin
                pc_next = next_pc_f;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: next-PC selection, redirect flushes,
// boot settle cycle and halt freeze.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                   PC_WIDTH  = PKG_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PKG_RESET_PC[PC_WIDTH-1:0],
    parameter int                   FLUSH_LEN = PKG_FLUSH_LEN
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] next_pc_f,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] curr_pc,
    output logic                fetch_valid,
    output logic                flush_fd,
    output logic                flush_dx,
    output logic                halted
);

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_LEN);

    logic [1:0]          state;
    logic [1:0]          flush_cnt;
    logic                freeze;
    logic [PC_WIDTH-1:0] pc_next;
    logic                redirect;
    redir_kind_t         kind;

    // BOOT holds PC at RESET_PC so the first imem read settles.
    assign freeze = (state == ST_BOOT) || (state == ST_HALTED) || halt;

    pc_next_mux #(
        .PC_WIDTH(PC_WIDTH)
    ) u_mux (
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .jump_en       (jump_en),
        .stall         (stall),
        .curr_pc       (curr_pc),
        .next_pc_f     (next_pc_f),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .pc_next       (pc_next),
        .redirect      (redirect),
        .kind          (kind)
    );

    assign fetch_valid = (state == ST_RUN) && !stall && !flush_fd;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_BOOT;
            curr_pc   <= RESET_PC;
            flush_cnt <= 2'd0;
            flush_fd  <= 1'b0;
            flush_dx  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            curr_pc <= pc_next;
            if (state == ST_BOOT) begin
                state <= ST_RUN;
            end else if (is_active(state)) begin
                if (halt) begin
                    state     <= ST_HALTED;
                    halted    <= 1'b1;
                    flush_fd  <= 1'b0;
                    flush_dx  <= 1'b0;
                    flush_cnt <= 2'd0;
                end else if (redirect) begin
                    state     <= ST_FLUSH;
                    flush_fd  <= 1'b1;
                    flush_dx  <= (kind == REDIR_BRANCH);
                    flush_cnt <= 2'd1;
                end else if (state == ST_FLUSH) begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state     <= ST_RUN;
                        flush_fd  <= 1'b0;
                        flush_dx  <= 1'b0;
                        flush_cnt <= 2'd0;
                    end else begin
                        flush_cnt <= flush_cnt + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the fetch stage is modelled
// as next_pc_f = curr_pc + 1.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] next_pc_f;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [11:0] branch_target = 12'd0;
    logic        jump_en = 1'b0;
    logic [11:0] jump_target = 12'd0;
    logic        halt = 1'b0;
    logic [11:0] curr_pc;
    logic        fetch_valid;
    logic        flush_fd;
    logic        flush_dx;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign next_pc_f = curr_pc + 12'd1;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .next_pc_f     (next_pc_f),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .halt          (halt),
        .curr_pc       (curr_pc),
        .fetch_valid   (fetch_valid),
        .flush_fd      (flush_fd),
        .flush_dx      (flush_dx),
        .halted        (halted)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump_en      = 1'b0;
        halt         = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        checks++;
        if ({curr_pc, fetch_valid, flush_fd, flush_dx, halted} !== {12'h000, 4'b0000}) begin
            errors++;
            $display("FAIL reset pc=%h fv=%b fd=%b dx=%b h=%b want 000 0 0 0 0",
                     curr_pc, fetch_valid, flush_fd, flush_dx, halted);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (curr_pc !== 12'(i) || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL boot_seq pc=%h fv=%b want %h 1", curr_pc, fetch_valid, 12'(i));
            end
        end
    endtask

    task automatic test_stall();
        step();
        step();
        checks++;
        if (curr_pc !== 12'h005) begin
            errors++;
            $display("FAIL stall_pre pc=%h want 005", curr_pc);
        end
        stall = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_fv fv=%b want 0", fetch_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (curr_pc !== 12'h005 || fetch_valid !== 1'b0 || flush_fd !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold pc=%h fv=%b fd=%b want 005 0 0",
                         curr_pc, fetch_valid, flush_fd);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (curr_pc !== 12'h006 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release pc=%h fv=%b want 006 1", curr_pc, fetch_valid);
        end
    endtask

    task automatic test_branch_vs_jump();
        step();
        step();
        checks++;
        if (curr_pc !== 12'h008) begin
            errors++;
            $display("FAIL bj_pre pc=%h want 008", curr_pc);
        end
        branch_taken  = 1'b1;
        branch_target = 12'h040;
        jump_en       = 1'b1;
        jump_target   = 12'h100;
        step();
        clear_inputs();
        #1;
        checks++;
        if ({curr_pc, flush_fd, flush_dx, fetch_valid} !== {12'h040, 3'b110}) begin
            errors++;
            $display("FAIL bj_redirect pc=%h fd=%b dx=%b fv=%b want 040 1 1 0",
                     curr_pc, flush_fd, flush_dx, fetch_valid);
        end
        step();
        checks++;
        if ({curr_pc, flush_fd, flush_dx, fetch_valid} !== {12'h041, 3'b001}) begin
            errors++;
            $display("FAIL bj_after pc=%h fd=%b dx=%b fv=%b want 041 0 0 1",
                     curr_pc, flush_fd, flush_dx, fetch_valid);
        end
    endtask

    task automatic test_jump_stall();
        jump_en     = 1'b1;
        jump_target = 12'h020;
        stall       = 1'b1;
        step();
        clear_inputs();
        #1;
        checks++;
        if ({curr_pc, flush_fd, flush_dx} !== {12'h020, 2'b10}) begin
            errors++;
            $display("FAIL jump_stall pc=%h fd=%b dx=%b want 020 1 0",
                     curr_pc, flush_fd, flush_dx);
        end
        step();
        checks++;
        if (curr_pc !== 12'h021 || flush_fd !== 1'b0) begin
            errors++;
            $display("FAIL jump_stall_after pc=%h fd=%b want 021 0", curr_pc, flush_fd);
        end
    endtask

    task automatic test_wrap();
        jump_en     = 1'b1;
        jump_target = 12'hFFE;
        step();
        clear_inputs();
        step();
        checks++;
        if (curr_pc !== 12'hFFF || flush_fd !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pre pc=%h fd=%b want fff 0", curr_pc, flush_fd);
        end
        step();
        checks++;
        if ({curr_pc, flush_fd, flush_dx, fetch_valid} !== {12'h000, 3'b001}) begin
            errors++;
            $display("FAIL wrap pc=%h fd=%b dx=%b fv=%b want 000 0 0 1",
                     curr_pc, flush_fd, flush_dx, fetch_valid);
        end
    endtask

    task automatic test_back_to_back();
        branch_taken  = 1'b1;
        branch_target = 12'h100;
        step();
        branch_taken = 1'b0;
        jump_en      = 1'b1;
        jump_target  = 12'h200;
        step();
        clear_inputs();
        #1;
        checks++;
        if ({curr_pc, flush_fd, flush_dx} !== {12'h200, 2'b10}) begin
            errors++;
            $display("FAIL b2b_restart pc=%h fd=%b dx=%b want 200 1 0",
                     curr_pc, flush_fd, flush_dx);
        end
        step();
        checks++;
        if (curr_pc !== 12'h201 || flush_fd !== 1'b0 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after pc=%h fd=%b fv=%b want 201 0 1",
                     curr_pc, flush_fd, fetch_valid);
        end
    endtask

    task automatic test_halt();
        jump_en     = 1'b1;
        jump_target = 12'h02F;
        step();
        clear_inputs();
        step();
        checks++;
        if (curr_pc !== 12'h030) begin
            errors++;
            $display("FAIL halt_pre pc=%h want 030", curr_pc);
        end
        halt          = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 12'h123;
        step();
        halt = 1'b0;
        #1;
        checks++;
        if ({curr_pc, halted, fetch_valid, flush_fd, flush_dx} !== {12'h030, 4'b1000}) begin
            errors++;
            $display("FAIL halt_enter pc=%h h=%b fv=%b fd=%b dx=%b want 030 1 0 0 0",
                     curr_pc, halted, fetch_valid, flush_fd, flush_dx);
        end
        jump_en     = 1'b1;
        jump_target = 12'h0AA;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (curr_pc !== 12'h030 || halted !== 1'b1 || flush_fd !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold pc=%h h=%b fd=%b want 030 1 0",
                         curr_pc, halted, flush_fd);
            end
        end
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({curr_pc, halted, fetch_valid} !== {12'h000, 2'b00}) begin
            errors++;
            $display("FAIL halt_reset pc=%h h=%b fv=%b want 000 0 0",
                     curr_pc, halted, fetch_valid);
        end
        step();
        checks++;
        if (curr_pc !== 12'h000 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_reboot pc=%h fv=%b want 000 1", curr_pc, fetch_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_vs_jump();
        test_jump_stall();
        test_wrap();
        test_back_to_back();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
